// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning policy/accelerator slice.
// Contents: datapath widths, action count, FSM state encoding of the
// epsilon-greedy selector, LFSR feedback mask and the explore-action helper.
package qlearn_pkg;

    localparam int Q_W       = 16;
    localparam int STATE_W   = 6;
    localparam int ACTION_W  = 4;
    localparam int N_ACTIONS = 15;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPLORE,
        S_SCAN,
        S_LAST,
        S_DONE
    } sel_state_t;

    // Maps a random sample onto a legal action code. The low nibble is tried
    // first, then the next nibble, and action 1 is the last-resort fallback,
    // so code 0 ("no action") can never be produced.
    function automatic logic [ACTION_W-1:0] explore_action(input logic [7:0] r, input int n);
        logic [ACTION_W-1:0] lo;
        logic [ACTION_W-1:0] hi;
        lo = r[3:0];
        hi = r[7:4];
        if (lo != '0 && int'(lo) <= n) begin
            return lo;
        end else if (hi != '0 && int'(hi) <= n) begin
            return hi;
        end
        return ACTION_W'(1);
    endfunction

endpackage

// File: rtl/epsilon_greedy_selector_if.sv
// Decision request/response and Q-RAM read bus of the epsilon-greedy selector.
//   start, state, epsilon       : decision request (environment -> selector)
//   busy, done, action, explored: decision result (selector -> environment)
//   q_rd_state, q_rd_action     : Q-RAM read address (selector -> RAM)
//   q_rd_data                   : Q-RAM read data, one cycle after the address
// Modports: master = environment/RAM side, slave = selector.
interface epsilon_greedy_selector_if;
    import qlearn_pkg::*;

    logic                       start;
    logic [STATE_W-1:0]         state;
    logic [15:0]                epsilon;
    logic [STATE_W-1:0]         q_rd_state;
    logic [ACTION_W-1:0]        q_rd_action;
    logic signed [Q_W-1:0]      q_rd_data;
    logic                       busy;
    logic                       done;
    logic [ACTION_W-1:0]        action;
    logic                       explored;

    modport master (
        output start, state, epsilon, q_rd_data,
        input  q_rd_state, q_rd_action, busy, done, action, explored
    );

    modport slave (
        input  start, state, epsilon, q_rd_data,
        output q_rd_state, q_rd_action, busy, done, action, explored
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the exploration noise source.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, loads the seed
//   value : current LFSR state, never zero
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);
    import qlearn_pkg::*;

    // An all-zero state would lock the register up, so a zero seed is remapped.
    localparam logic [15:0] RESET_VALUE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RESET_VALUE;
        end else begin
            value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/epsilon_greedy_selector.sv
// Epsilon-greedy policy stage feeding the Q-learning accelerator.
// On an accepted start it either explores (LFSR-derived action) or scans the
// N_ACTIONS Q-values of the latched state and returns the signed arg-max,
// lowest index winning ties.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any decision in progress)
//   bus : request/result handshake and Q-RAM read port (slave modport)
module epsilon_greedy_selector #(
    parameter int          N_ACTIONS = qlearn_pkg::N_ACTIONS,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    epsilon_greedy_selector_if.slave  bus
);
    import qlearn_pkg::*;

    localparam logic [ACTION_W-1:0] FIRST_ACTION = ACTION_W'(1);
    localparam logic [ACTION_W-1:0] LAST_ACTION  = ACTION_W'(N_ACTIONS);

    sel_state_t             fsm;
    logic [15:0]            lfsr;
    logic [7:0]             r_lat;     // only the two low nibbles pick an action
    logic [ACTION_W-1:0]    pend_idx;  // action whose data is on q_rd_data now
    logic [ACTION_W-1:0]    best_idx;
    logic signed [Q_W-1:0]  best_q;
    logic                   take;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    // The first returning word seeds the running max; later words win only
    // when strictly greater, which keeps the lowest index on ties.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        take = 1'b0;
        if (pend_idx == FIRST_ACTION || bus.q_rd_data > best_q) begin
            take = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm             <= S_IDLE;
            r_lat           <= '0;
            pend_idx        <= '0;
            best_idx        <= '0;
            best_q          <= '0;
            bus.q_rd_state  <= '0;
            bus.q_rd_action <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.action      <= '0;
            bus.explored    <= 1'b0;
        end else begin
            // The RAM answers one cycle late, so the address is tracked a cycle behind.
            pend_idx <= bus.q_rd_action;

            case (fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.q_rd_state <= bus.state;
                        r_lat          <= lfsr[7:0];
                        bus.busy       <= 1'b1;
                        if (lfsr < bus.epsilon) begin
                            fsm <= S_EXPLORE;
                        end else begin
                            fsm             <= S_SCAN;
                            bus.q_rd_action <= FIRST_ACTION;
                        end
                    end
                end

                S_EXPLORE: begin
                    bus.action   <= explore_action(r_lat, N_ACTIONS);
                    bus.explored <= 1'b1;
                    bus.done     <= 1'b1;
                    fsm          <= S_DONE;
                end

                S_SCAN: begin
                    if (pend_idx != '0 && take) begin
                        best_q   <= bus.q_rd_data;
                        best_idx <= pend_idx;
                    end
                    if (bus.q_rd_action == LAST_ACTION) begin
                        fsm <= S_LAST;
                    end else begin
                        bus.q_rd_action <= bus.q_rd_action + ACTION_W'(1);
                    end
                end

                S_LAST: begin
                    // Final word is folded in directly rather than via best_q.
                    bus.action      <= take ? pend_idx : best_idx;
                    bus.explored    <= 1'b0;
                    bus.q_rd_action <= '0;
                    bus.done        <= 1'b1;
                    fsm             <= S_DONE;
                end

                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    fsm      <= S_IDLE;
                end

                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
// Self-checking bench for epsilon_greedy_selector: table of decision vectors,
// a scoreboard queue of expected results, a behavioural Q-RAM and an
// independent LFSR model used to predict exploration outcomes.
module tb_epsilon_greedy_selector;
    import qlearn_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [15:0]        eps;
        logic [5:0]         st;
        logic [3:0]         greedy;   // expected arg-max if the decision is greedy
        logic [15:1][15:0]  q;        // Q-values for actions 1..15
    } vec_t;

    typedef struct {
        logic [3:0] action;
        logic       explored;
        logic [5:0] st;
        int         latency;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    epsilon_greedy_selector_if bus();

    epsilon_greedy_selector #(.N_ACTIONS(15), .LFSR_SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read Q-RAM.
    logic signed [15:0] q_mem [64][16];
    always @(posedge clk) bus.q_rd_data <= q_mem[bus.q_rd_state][bus.q_rd_action];

    // Reference LFSR tracking the DUT's noise source cycle by cycle.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int   checks = 0;
    int   errors = 0;
    int   zero_actions = 0;
    exp_t sb[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] model_pick(input logic [15:0] r);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = r[3:0];
        hi = r[7:4];
        if (lo != 4'd0) return lo;
        if (hi != 4'd0) return hi;
        return 4'd1;
    endfunction

    function automatic vec_t mk(input logic [15:0] eps, input logic [5:0] st, input logic [3:0] g);
        vec_t v;
        v.eps = eps; v.st = st; v.greedy = g; v.q = '0;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_action"}, bus.action, 0);
        check({tag, "_explored"}, bus.explored, 0);
        check({tag, "_q_rd_action"}, bus.q_rd_action, 0);
        check({tag, "_q_rd_state"}, bus.q_rd_state, 0);
        check({tag, "_lfsr"}, dut.u_lfsr.value, SEED);
    endtask

    // Drives one decision starting at a negedge in an IDLE cycle and follows it
    // to done plus one cycle, so a following call starts back-to-back.
    task automatic run(input vec_t v, input bit hold_start, input bit perturb);
        exp_t e, x;
        bit   step_ok, busy_ok;
        int   got_cyc;
        for (int k = 0; k < 16; k++) q_mem[v.st][k] = (k == 0) ? 16'sd0 : v.q[k];
        bus.state   = v.st;
        bus.epsilon = v.eps;
        bus.start   = 1'b1;
        e.explored  = (m_lfsr < v.eps);
        e.action    = e.explored ? model_pick(m_lfsr) : v.greedy;
        e.st        = v.st;
        e.latency   = e.explored ? 2 : 17;
        sb.push_back(e);
        @(posedge clk);
        step_ok = 1'b1; busy_ok = 1'b1; got_cyc = 0;
        for (int cyc = 1; cyc <= 40 && got_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !hold_start) bus.start = 1'b0;
            if (perturb && cyc == 5) begin
                bus.state   = ~v.st;
                bus.epsilon = ~v.eps;
            end
            if (!e.explored && cyc <= 15 && bus.q_rd_action != 4'(cyc)) step_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                got_cyc = cyc;
                x = sb.pop_front();
                check("action", bus.action, x.action);
                check("explored", bus.explored, x.explored);
                check("q_rd_state_latched", bus.q_rd_state, x.st);
                check("q_rd_action_idle", bus.q_rd_action, 0);
                if (bus.action == 4'd0) zero_actions++;
            end
        end
        if (got_cyc == 0) void'(sb.pop_front());
        check("done_latency", got_cyc, e.latency);
        check("busy_window", busy_ok, 1);
        if (!e.explored) check("q_rd_action_step", step_ok, 1);
        bus.start = 1'b0;
        @(negedge clk);
        check("done_pulse_single", bus.done, 0);
        check("busy_released", bus.busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        vecs[0] = mk(16'h0000, 6'd5, 4'd9);
        vecs[0].q[1] = 16'd5; vecs[0].q[2] = -16'sd3;
        vecs[0].q[9] = 16'd200; vecs[0].q[12] = 16'd200;
        vecs[1] = mk(16'h0000, 6'd6, 4'd1);
        for (int k = 1; k <= 15; k++) vecs[1].q[k] = 16'(-k);
        vecs[2] = mk(16'h0000, 6'd7, 4'd1);
        for (int k = 1; k <= 15; k++) vecs[2].q[k] = 16'h7FFF;
        vecs[3] = mk(16'h0000, 6'd8, 4'd15);
        vecs[3].q[15] = 16'd1;
        vecs[4] = mk(16'h0000, 6'd9, 4'd4);
        for (int k = 1; k <= 15; k++) vecs[4].q[k] = -16'sd5;
        vecs[4].q[3] = 16'h8000; vecs[4].q[4] = 16'd1;
        vecs[5] = mk(16'hFFFF, 6'd10, 4'd1);
        vecs[6] = mk(16'hFFFF, 6'd63, 4'd1);
        vecs[7] = mk(16'h0001, 6'd0, 4'd15);
        for (int k = 1; k <= 15; k++) vecs[7].q[k] = 16'(k);
        vecs[8] = mk(16'h0000, 6'd11, 4'd2);
        for (int k = 1; k <= 15; k++) vecs[8].q[k] = 16'h8000;
        vecs[8].q[2] = 16'h8001;

        for (int s = 0; s < 64; s++)
            for (int k = 0; k < 16; k++) q_mem[s][k] = 16'sd0;

        rst = 1'b1; bus.start = 1'b0; bus.state = '0; bus.epsilon = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run(vecs[i], 1'b0, 1'b0);

        // start held through a whole scan, then a back-to-back decision
        run(vecs[0], 1'b1, 1'b0);
        run(vecs[3], 1'b0, 1'b0);

        // state/epsilon changed mid-scan
        run(vecs[4], 1'b0, 1'b1);

        // reset in cycle 8 of a greedy scan
        bus.state = 6'd5; bus.epsilon = 16'h0000; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle_action", bus.action, 0);
        run(vecs[0], 1'b0, 1'b0);

        // long exploration run
        zero_actions = 0;
        for (int i = 0; i < 1000; i++) run(vecs[5], 1'b0, 1'b0);
        check("explore_never_zero", zero_actions, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
